// File: rtl/decode_stage_v2.sv
// RV32 decode stage: decodes the IF/ID word and registers the control bundle into ID/EX,
// with valid tracking, downstream hold, load-use interlock, illegal flagging and optional M decode.
module decode_stage_v2 #(
  parameter int XLEN      = 32,
  parameter int ENABLE_M  = 1,
  parameter int ALUCODE_W = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          ir,
  input  logic                 in_valid,
  input  logic [XLEN-1:0]      pc_in,
  input  logic [XLEN-1:0]      notbranch_in,
  input  logic                 flush,
  input  logic                 stall_in,
  output logic [4:0]           srcreg1_num,
  output logic [4:0]           srcreg2_num,
  output logic                 hazard_stall,
  output logic                 out_valid,
  output logic                 illegal,
  output logic [4:0]           dstreg_num,
  output logic [XLEN-1:0]      imm,
  output logic [ALUCODE_W-1:0] alucode,
  output logic                 using_r2,
  output logic                 using_pc,
  output logic                 write_reg,
  output logic [2:0]           info_load,
  output logic [1:0]           info_store,
  output logic [3:0]           info_branch,
  output logic [XLEN-1:0]      pc_out,
  output logic [XLEN-1:0]      notbranch_out,
  output logic [4:0]           ereg1_addr,
  output logic [4:0]           ereg2_addr
);
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_ROP    = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;

  localparam logic [ALUCODE_W-1:0] ALU_ADD    = ALUCODE_W'(0);
  localparam logic [ALUCODE_W-1:0] ALU_SUB    = ALUCODE_W'(1);
  localparam logic [ALUCODE_W-1:0] ALU_SLL    = ALUCODE_W'(2);
  localparam logic [ALUCODE_W-1:0] ALU_SLT    = ALUCODE_W'(3);
  localparam logic [ALUCODE_W-1:0] ALU_SLTU   = ALUCODE_W'(4);
  localparam logic [ALUCODE_W-1:0] ALU_XOR    = ALUCODE_W'(5);
  localparam logic [ALUCODE_W-1:0] ALU_SRL    = ALUCODE_W'(6);
  localparam logic [ALUCODE_W-1:0] ALU_SRA    = ALUCODE_W'(7);
  localparam logic [ALUCODE_W-1:0] ALU_OR     = ALUCODE_W'(8);
  localparam logic [ALUCODE_W-1:0] ALU_AND    = ALUCODE_W'(9);
  localparam logic [ALUCODE_W-1:0] ALU_LUI    = ALUCODE_W'(10);
  localparam logic [ALUCODE_W-1:0] ALU_UNUSED = ALUCODE_W'(15);

  localparam logic [2:0] NOTLOAD   = 3'd7;
  localparam logic [1:0] NOTSTORE  = 2'd3;
  localparam logic [3:0] NOTBRANCH = 4'd0;
  localparam logic [3:0] BR_JAL    = 4'd7;
  localparam logic [3:0] BR_JALR   = 4'd8;

  function automatic logic [ALUCODE_W-1:0] alu_base(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  alu_base = alt ? ALU_SUB : ALU_ADD;
      3'b001:  alu_base = ALU_SLL;
      3'b010:  alu_base = ALU_SLT;
      3'b011:  alu_base = ALU_SLTU;
      3'b100:  alu_base = ALU_XOR;
      3'b101:  alu_base = alt ? ALU_SRA : ALU_SRL;
      3'b110:  alu_base = ALU_OR;
      default: alu_base = ALU_AND;
    endcase
  endfunction

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [4:0] rd;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_shamt;

  assign opcode      = ir[6:0];
  assign funct3      = ir[14:12];
  assign funct7      = ir[31:25];
  assign rd          = ir[11:7];
  assign srcreg1_num = ir[19:15];
  assign srcreg2_num = ir[24:20];

  assign imm_i     = {{(XLEN-12){ir[31]}}, ir[31:20]};
  assign imm_s     = {{(XLEN-12){ir[31]}}, ir[31:25], ir[11:7]};
  assign imm_b     = {{(XLEN-12){ir[31]}}, ir[7], ir[30:25], ir[11:8], 1'b0};
  assign imm_u     = {{(XLEN-31){ir[31]}}, ir[30:12], 12'b0};
  assign imm_j     = {{(XLEN-20){ir[31]}}, ir[19:12], ir[20], ir[30:21], 1'b0};
  assign imm_shamt = {{(XLEN-5){1'b0}}, ir[24:20]};

  logic                 bad, use1, use2, write_next, using_r2_next, using_pc_next;
  logic [ALUCODE_W-1:0] alucode_next;
  logic [XLEN-1:0]      imm_next;
  logic [2:0]           load_next;
  logic [1:0]           store_next;
  logic [3:0]           branch_next;

  always_comb begin
    bad           = 1'b0;
    use1          = 1'b0;
    use2          = 1'b0;
    write_next    = 1'b0;
    using_r2_next = 1'b0;
    using_pc_next = 1'b0;
    alucode_next  = ALU_UNUSED;
    imm_next      = '0;
    load_next     = NOTLOAD;
    store_next    = NOTSTORE;
    branch_next   = NOTBRANCH;
    case (opcode)
      OP_IMM: begin
        use1         = 1'b1;
        write_next   = 1'b1;
        alucode_next = alu_base(funct3, funct3 == 3'b101 && ir[30]);
        imm_next     = (funct3[1:0] == 2'b01) ? imm_shamt : imm_i;
      end
      OP_ROP: begin
        use1          = 1'b1;
        use2          = 1'b1;
        write_next    = 1'b1;
        using_r2_next = 1'b1;
        alucode_next  = alu_base(funct3, ir[30]);
        if (funct7 == 7'b0000001 && ENABLE_M != 0)
          alucode_next = ALUCODE_W'({2'b10, funct3});
        else if (!(funct7 == 7'b0000000 ||
                   (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101))))
          bad = 1'b1;
      end
      OP_LUI: begin
        write_next   = 1'b1;
        alucode_next = ALU_LUI;
        imm_next     = imm_u;
      end
      OP_AUIPC: begin
        write_next    = 1'b1;
        using_pc_next = 1'b1;
        alucode_next  = ALU_ADD;
        imm_next      = imm_u;
      end
      OP_JAL: begin
        write_next    = 1'b1;
        using_pc_next = 1'b1;
        alucode_next  = ALU_ADD;
        imm_next      = imm_j;
        branch_next   = BR_JAL;
      end
      OP_JALR: begin
        use1         = 1'b1;
        write_next   = 1'b1;
        alucode_next = ALU_ADD;
        imm_next     = imm_i;
        branch_next  = BR_JALR;
      end
      OP_BRANCH: begin
        use1          = 1'b1;
        use2          = 1'b1;
        using_pc_next = 1'b1;
        alucode_next  = ALU_ADD;
        imm_next      = imm_b;
        // Beq..Bne map to 1..2, Blt..Bgeu to 3..6.
        if (funct3[2:1] == 2'b01) bad = 1'b1;
        else branch_next = funct3[2] ? {1'b0, funct3} - 4'd1 : {1'b0, funct3} + 4'd1;
      end
      OP_STORE: begin
        use1         = 1'b1;
        use2         = 1'b1;
        alucode_next = ALU_ADD;
        imm_next     = imm_s;
        if (funct3 >= 3'b011) bad = 1'b1;
        else store_next = funct3[1:0];
      end
      OP_LOAD: begin
        use1         = 1'b1;
        write_next   = 1'b1;
        alucode_next = ALU_ADD;
        imm_next     = imm_i;
        if (funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111) bad = 1'b1;
        else load_next = funct3;
      end
      default: bad = 1'b1;
    endcase
  end

  assign hazard_stall = out_valid && (info_load != NOTLOAD) && (dstreg_num != 5'd0) &&
                        in_valid && !flush &&
                        ((use1 && srcreg1_num == dstreg_num) || (use2 && srcreg2_num == dstreg_num));

  logic take;
  assign take = !rst && in_valid && !flush && !stall_in && !hazard_stall;

  // Everything except a plain stall rewrites the bundle; a non-taken cycle writes a bubble.
  always_ff @(posedge clk) begin
    if (rst || flush || !stall_in) begin
      out_valid <= take;
      illegal   <= take && bad;
      if (rst) begin
        pc_out        <= '0;
        notbranch_out <= '0;
      end else if (take) begin
        pc_out        <= pc_in;
        notbranch_out <= notbranch_in;
      end
      if (take && !bad) begin
        write_reg   <= write_next;
        dstreg_num  <= write_next ? rd : 5'd0;
        imm         <= imm_next;
        alucode     <= alucode_next;
        using_r2    <= using_r2_next;
        using_pc    <= using_pc_next;
        info_load   <= load_next;
        info_store  <= store_next;
        info_branch <= branch_next;
        ereg1_addr  <= use1 ? srcreg1_num : 5'd0;
        ereg2_addr  <= use2 ? srcreg2_num : 5'd0;
      end else begin
        write_reg   <= 1'b0;
        dstreg_num  <= 5'd0;
        imm         <= '0;
        alucode     <= ALU_UNUSED;
        using_r2    <= 1'b0;
        using_pc    <= 1'b0;
        info_load   <= NOTLOAD;
        info_store  <= NOTSTORE;
        info_branch <= NOTBRANCH;
        ereg1_addr  <= 5'd0;
        ereg2_addr  <= 5'd0;
      end
    end
  end
endmodule

// File: tb/tb_decode_stage_v2.sv
// Scoreboard bench for decode_stage_v2: two instances (ENABLE_M=0/1) checked against an
// instruction-level reference model; driver pushes expectations, monitor pops and compares.
module tb_decode_stage_v2;
  localparam bit [4:0] A_ADD = 5'd0, A_SUB = 5'd1, A_SLL = 5'd2, A_SLT = 5'd3, A_SLTU = 5'd4;
  localparam bit [4:0] A_XOR = 5'd5, A_SRL = 5'd6, A_SRA = 5'd7, A_OR = 5'd8, A_AND = 5'd9;
  localparam bit [4:0] A_LUI = 5'd10, A_UNUSED = 5'd15;
  localparam bit [2:0] NOTLOAD = 3'd7;
  localparam bit [1:0] NOTSTORE = 2'd3;
  localparam bit [3:0] NOTBRANCH = 4'd0, B_JAL = 4'd7, B_JALR = 4'd8;

  typedef struct packed {
    bit valid; bit illegal; bit [4:0] dst; bit [31:0] imm; bit [4:0] alu;
    bit r2; bit upc; bit wr; bit [2:0] ld; bit [1:0] st; bit [3:0] br;
    bit [31:0] pco; bit [31:0] nbo; bit [4:0] e1; bit [4:0] e2;
    bit u1; bit u2;
  } bundle_t;
  typedef struct { bit [31:0] w; bit hz[2]; bit [4:0] s1; bit [4:0] s2; bundle_t b[2]; } item_t;

  logic clk = 1'b0;
  logic rst, in_valid, flush, stall_in;
  logic [31:0] ir, pc_in, notbranch_in;
  logic [4:0]  s1_o [2], s2_o [2], dst_o [2], e1_o [2], e2_o [2], alu_o [2];
  logic        hz_o [2], ov_o [2], ill_o [2], r2_o [2], upc_o [2], wr_o [2];
  logic [31:0] imm_o [2], pco_o [2], nbo_o [2];
  logic [2:0]  ld_o [2];
  logic [1:0]  st_o [2];
  logic [3:0]  br_o [2];

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    decode_stage_v2 #(.XLEN(32), .ENABLE_M(gi), .ALUCODE_W(5)) dut (
      .clk(clk), .rst(rst), .ir(ir), .in_valid(in_valid), .pc_in(pc_in),
      .notbranch_in(notbranch_in), .flush(flush), .stall_in(stall_in),
      .srcreg1_num(s1_o[gi]), .srcreg2_num(s2_o[gi]), .hazard_stall(hz_o[gi]),
      .out_valid(ov_o[gi]), .illegal(ill_o[gi]), .dstreg_num(dst_o[gi]), .imm(imm_o[gi]),
      .alucode(alu_o[gi]), .using_r2(r2_o[gi]), .using_pc(upc_o[gi]), .write_reg(wr_o[gi]),
      .info_load(ld_o[gi]), .info_store(st_o[gi]), .info_branch(br_o[gi]),
      .pc_out(pco_o[gi]), .notbranch_out(nbo_o[gi]),
      .ereg1_addr(e1_o[gi]), .ereg2_addr(e2_o[gi])
    );
  end

  int checks = 0, errors = 0, txn = 0;
  item_t q[$];
  bundle_t mst[2];
  bit [31:0] pc_ctr;
  bit took;

  function automatic bundle_t bubble(bit [31:0] pco, bit [31:0] nbo);
    bundle_t b = '0;
    b.alu = A_UNUSED; b.ld = NOTLOAD; b.st = NOTSTORE; b.br = NOTBRANCH;
    b.pco = pco; b.nbo = nbo;
    return b;
  endfunction

  function automatic bit [4:0] alu_of(bit [2:0] f3, bit alt);
    case (f3)
      3'd0: return alt ? A_SUB : A_ADD;
      3'd1: return A_SLL;
      3'd2: return A_SLT;
      3'd3: return A_SLTU;
      3'd4: return A_XOR;
      3'd5: return alt ? A_SRA : A_SRL;
      3'd6: return A_OR;
      default: return A_AND;
    endcase
  endfunction

  // Instruction-level reference: what a legal instruction means, with immediates from arithmetic.
  function automatic bundle_t decode(bit [31:0] w, bit en_m);
    bundle_t d = bubble(0, 0);
    bit bad = 0;
    bit a1, a2;
    int sgn = w[31] ? -1 : 0;
    bit [2:0] f3 = w[14:12];
    bit [6:0] f7 = w[31:25];
    int i_imm = $signed(w) >>> 20;
    int s_imm = (($signed(w) >>> 25) * 32) + int'(w[11:7]);
    int b_imm = sgn * 4096 + int'(w[7]) * 2048 + int'(w[30:25]) * 32 + int'(w[11:8]) * 2;
    int j_imm = sgn * (1 << 20) + int'(w[19:12]) * 4096 + int'(w[20]) * 2048 + int'(w[30:21]) * 2;
    case (w[6:0])
      7'h13: begin
        d.u1 = 1; d.wr = 1; d.alu = alu_of(f3, f3 == 3'd5 && w[30]);
        d.imm = (f3 == 3'd1 || f3 == 3'd5) ? 32'(w[24:20]) : 32'(i_imm);
      end
      7'h33: begin
        d.u1 = 1; d.u2 = 1; d.wr = 1; d.r2 = 1;
        if (f7 == 7'h01 && en_m) d.alu = 5'(16 + int'(f3));
        else if (f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5))) d.alu = alu_of(f3, f7 == 7'h20);
        else bad = 1;
      end
      7'h37: begin d.wr = 1; d.alu = A_LUI; d.imm = w & 32'hFFFF_F000; end
      7'h17: begin d.wr = 1; d.upc = 1; d.alu = A_ADD; d.imm = w & 32'hFFFF_F000; end
      7'h6f: begin d.wr = 1; d.upc = 1; d.alu = A_ADD; d.br = B_JAL; d.imm = 32'(j_imm); end
      7'h67: begin d.wr = 1; d.u1 = 1; d.alu = A_ADD; d.br = B_JALR; d.imm = 32'(i_imm); end
      7'h63: begin
        d.u1 = 1; d.u2 = 1; d.upc = 1; d.alu = A_ADD; d.imm = 32'(b_imm);
        case (f3)
          3'd0: d.br = 4'd1;
          3'd1: d.br = 4'd2;
          3'd4: d.br = 4'd3;
          3'd5: d.br = 4'd4;
          3'd6: d.br = 4'd5;
          3'd7: d.br = 4'd6;
          default: bad = 1;
        endcase
      end
      7'h23: begin
        d.u1 = 1; d.u2 = 1; d.alu = A_ADD; d.imm = 32'(s_imm);
        if (f3 < 3'd3) d.st = f3[1:0]; else bad = 1;
      end
      7'h03: begin
        d.u1 = 1; d.wr = 1; d.alu = A_ADD; d.imm = 32'(i_imm);
        if (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) d.ld = f3; else bad = 1;
      end
      default: bad = 1;
    endcase
    if (d.wr) d.dst = w[11:7];
    if (d.u1) d.e1 = w[19:15];
    if (d.u2) d.e2 = w[24:20];
    if (bad) begin
      a1 = d.u1; a2 = d.u2;
      d = bubble(0, 0);
      d.u1 = a1; d.u2 = a2; d.illegal = 1;
    end
    d.valid = 1;
    return d;
  endfunction

  function automatic bundle_t step(bundle_t cur, bit r, bit fl, bit st, bit iv, bit [31:0] w,
                                   bit [31:0] pc, bit [31:0] nb, bit en_m, output bit hz);
    bundle_t d = decode(w, en_m);
    hz = cur.valid && cur.ld != NOTLOAD && cur.dst != 0 && iv && !fl &&
         ((d.u1 && w[19:15] == cur.dst) || (d.u2 && w[24:20] == cur.dst));
    if (r) return bubble(0, 0);
    if (fl) return bubble(cur.pco, cur.nbo);
    if (st) return cur;
    if (hz || !iv) return bubble(cur.pco, cur.nbo);
    d.pco = pc; d.nbo = nb;
    return d;
  endfunction

  function automatic bit [31:0] gen();
    bit [6:0] ops [10] = '{7'h13, 7'h33, 7'h37, 7'h17, 7'h6f, 7'h67, 7'h63, 7'h23, 7'h03, 7'h33};
    bit [6:0] f7s [4] = '{7'h00, 7'h20, 7'h01, 7'h00};
    bit [31:0] w = $urandom();
    if ($urandom_range(0, 15) == 0) return w;
    w[6:0]   = ops[$urandom_range(0, 9)];
    w[11:7]  = 5'($urandom_range(0, 3));
    w[19:15] = 5'($urandom_range(0, 3));
    w[24:20] = 5'($urandom_range(0, 3));
    if (w[6:0] == 7'h33 && $urandom_range(0, 7) != 0) w[31:25] = f7s[$urandom_range(0, 3)];
    return w;
  endfunction

  task automatic chk(string n, int k, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (ENABLE_M=%0d): got %h expected %h", n, k, act, exp);
    end
  endtask

  task automatic cyc(bit r, bit iv, bit [31:0] w, bit fl, bit st);
    item_t it;
    bit h;
    @(negedge clk);
    rst = r; in_valid = iv; ir = w; flush = fl; stall_in = st;
    pc_in = pc_ctr; notbranch_in = pc_ctr + 32'd4;
    it.w = w; it.s1 = w[19:15]; it.s2 = w[24:20];
    for (int k = 0; k < 2; k++) begin
      mst[k] = step(mst[k], r, fl, st, iv, w, pc_ctr, pc_ctr + 32'd4, k == 1, h);
      it.hz[k] = h;
      it.b[k] = mst[k];
    end
    q.push_back(it);
    took = !r && !fl && !st && iv && !it.hz[1];
    if (took) pc_ctr += 32'd4;
  endtask

  // Monitor: combinational outputs before the edge, registered bundle just after it.
  initial begin
    item_t it;
    forever begin
      @(negedge clk);
      #3;
      if (q.size() != 0) begin
        it = q.pop_front();
        for (int k = 0; k < 2; k++) begin
          chk("hazard_stall", k, 32'(hz_o[k]), 32'(it.hz[k]));
          chk("srcreg1_num", k, 32'(s1_o[k]), 32'(it.s1));
          chk("srcreg2_num", k, 32'(s2_o[k]), 32'(it.s2));
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
          chk("out_valid", k, 32'(ov_o[k]), 32'(it.b[k].valid));
          chk("illegal", k, 32'(ill_o[k]), 32'(it.b[k].illegal));
          chk("dstreg_num", k, 32'(dst_o[k]), 32'(it.b[k].dst));
          chk("imm", k, imm_o[k], it.b[k].imm);
          chk("alucode", k, 32'(alu_o[k]), 32'(it.b[k].alu));
          chk("using_r2", k, 32'(r2_o[k]), 32'(it.b[k].r2));
          chk("using_pc", k, 32'(upc_o[k]), 32'(it.b[k].upc));
          chk("write_reg", k, 32'(wr_o[k]), 32'(it.b[k].wr));
          chk("info_load", k, 32'(ld_o[k]), 32'(it.b[k].ld));
          chk("info_store", k, 32'(st_o[k]), 32'(it.b[k].st));
          chk("info_branch", k, 32'(br_o[k]), 32'(it.b[k].br));
          chk("pc_out", k, pco_o[k], it.b[k].pco);
          chk("notbranch_out", k, nbo_o[k], it.b[k].nbo);
          chk("ereg1_addr", k, 32'(e1_o[k]), 32'(it.b[k].e1));
          chk("ereg2_addr", k, 32'(e2_o[k]), 32'(it.b[k].e2));
        end
        txn++;
        $display("txn %0d ir=%h hz=%0b ov=%0b ill=%0b alu=%0d imm=%h", txn, it.w,
                 hz_o[1], ov_o[1], ill_o[1], alu_o[1], imm_o[1]);
      end
    end
  end

  initial begin
    bit [31:0] w;
    bit r, fl, st, iv;
    rst = 1; in_valid = 0; ir = '0; flush = 0; stall_in = 0; pc_in = '0; notbranch_in = '0;
    pc_ctr = 32'h100;
    mst[0] = bubble(0, 0);
    mst[1] = bubble(0, 0);
    repeat (2) @(negedge clk);

    cyc(0, 1, 32'h00500093, 0, 0);            // addi x1,x0,5
    cyc(0, 1, 32'h0000A103, 0, 0);            // lw x2,0(x1)
    cyc(0, 1, 32'h002101B3, 0, 0);            // add x3,x2,x2 -> interlock
    cyc(0, 1, 32'h002101B3, 0, 0);            // add issues
    cyc(0, 1, 32'h00500093, 0, 0);
    repeat (3) cyc(0, 1, $urandom(), 0, 1);   // downstream hold
    cyc(0, 1, 32'h00500093, 1, 1);            // flush beats hold
    cyc(0, 1, 32'h022081B3, 0, 0);            // mul x3,x1,x2
    cyc(0, 1, 32'hFFFFFFFF, 0, 0);
    cyc(0, 1, 32'h00002063, 0, 0);            // branch funct3=010
    cyc(0, 1, 32'hFE000EE3, 0, 0);            // beq x0,x0,-4
    cyc(0, 1, 32'h0000A103, 0, 0);
    cyc(1, 1, 32'h002101B3, 0, 0);            // reset mid-stream
    cyc(0, 1, 32'h002101B3, 0, 0);

    w = gen();
    repeat (600) begin
      r  = ($urandom_range(0, 99) < 2);
      fl = ($urandom_range(0, 99) < 5);
      st = ($urandom_range(0, 99) < 15);
      iv = ($urandom_range(0, 99) < 85);
      cyc(r, iv, w, fl, st);
      if (took || r || fl) w = gen();
    end

    repeat (3) @(negedge clk);
    chk("queue_drained", 0, 32'(q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
